// File: rtl/ps2_dir_queue.sv
// PS/2 set-2 keyboard front end: decodes make/break/extended sequences into
// per-player direction turns, drops illegal turns and queues the rest per player.
module ps2_dir_queue #(
    parameter int NUM_PLAYERS = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ps2_code_new,
    input  logic [7:0]               ps2_code,
    input  logic                     step,
    output logic [2*NUM_PLAYERS-1:0] dirs,
    output logic                     restart,
    output logic [NUM_PLAYERS-1:0]   overflow
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_SPACE = 8'h29;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } prefix_t;

    // Opposite directions differ only in bit 0 with this encoding.
    function automatic logic [1:0] init_dir(input int p);
        logic [1:0] d;
        case (p)
            0:       d = DIR_RIGHT;
            1:       d = DIR_LEFT;
            2:       d = DIR_UP;
            default: d = DIR_DOWN;
        endcase
        return d;
    endfunction

    // Returns {hit, dir} for player p's row of the keymap.
    function automatic logic [2:0] key_lookup(input int p, input logic ext, input logic [7:0] code);
        logic [7:0] c_up;
        logic [7:0] c_dn;
        logic [7:0] c_lt;
        logic [7:0] c_rt;
        logic       need_ext;
        logic [2:0] res;
        case (p)
            0: begin
                need_ext = 1'b0;
                c_up = 8'h1D; c_dn = 8'h1B; c_lt = 8'h1C; c_rt = 8'h23;
            end
            1: begin
                need_ext = 1'b1;
                c_up = 8'h75; c_dn = 8'h72; c_lt = 8'h6B; c_rt = 8'h74;
            end
            2: begin
                need_ext = 1'b0;
                c_up = 8'h75; c_dn = 8'h72; c_lt = 8'h6B; c_rt = 8'h74;
            end
            default: begin
                need_ext = 1'b0;
                c_up = 8'h43; c_dn = 8'h42; c_lt = 8'h3B; c_rt = 8'h4B;
            end
        endcase
        res = 3'b000;
        if (ext == need_ext) begin
            if (code == c_up)      res = {1'b1, DIR_UP};
            else if (code == c_dn) res = {1'b1, DIR_DOWN};
            else if (code == c_lt) res = {1'b1, DIR_LEFT};
            else if (code == c_rt) res = {1'b1, DIR_RIGHT};
        end
        return res;
    endfunction

    logic [1:0] hist_reg;
    logic       byte_event;
    prefix_t    prefix_reg;
    prefix_t    prefix_next;
    logic       ext_flag;
    logic       brk_flag;
    logic       byte_valid;
    logic       make_valid;
    logic       restart_hit;
    logic       restart_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hist_reg <= 2'b00;
        end else begin
            hist_reg <= {hist_reg[0], ps2_code_new};
        end
    end

    assign byte_event = (hist_reg == 2'b01);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prefix_reg <= PS_IDLE;
        end else begin
            prefix_reg <= prefix_next;
        end
    end

    always_comb begin
        prefix_next = prefix_reg;
        byte_valid  = 1'b0;
        ext_flag    = (prefix_reg == PS_EXT) || (prefix_reg == PS_EXT_BRK);
        brk_flag    = (prefix_reg == PS_BRK) || (prefix_reg == PS_EXT_BRK);
        if (byte_event) begin
            if (ps2_code == CODE_EXT) begin
                prefix_next = brk_flag ? PS_EXT_BRK : PS_EXT;
            end else if (ps2_code == CODE_BRK) begin
                prefix_next = ext_flag ? PS_EXT_BRK : PS_BRK;
            end else begin
                prefix_next = PS_IDLE;
                byte_valid  = 1'b1;
            end
        end
    end

    assign make_valid  = byte_valid && !brk_flag;
    assign restart_hit = byte_valid && brk_flag && !ext_flag && (ps2_code == CODE_SPACE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            restart_reg <= 1'b0;
        end else begin
            restart_reg <= restart_hit;
        end
    end

    assign restart = restart_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [1:0]    mem_reg [QUEUE_DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [1:0]    last_reg;
            logic [1:0]    dir_reg;
            logic          ovf_reg;
            logic [2:0]    lookup;
            logic [1:0]    dec_dir;
            logic          empty;
            logic          full;
            logic          pop;
            logic          want_push;
            logic          push;

            assign lookup  = key_lookup(gi, ext_flag, ps2_code);
            assign dec_dir = lookup[1:0];
            assign empty   = (wr_ptr_reg == rd_ptr_reg);
            assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                             (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

            // last tracks the queue tail, which equals dirs once the queue drains.
            assign want_push = make_valid && lookup[2] &&
                               (dec_dir != last_reg) && (dec_dir != (last_reg ^ 2'b01));
            assign pop  = step && !empty;
            assign push = want_push && (!full || pop);

            always_ff @(posedge clock) begin
                if (!reset_n || restart_hit) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    last_reg   <= init_dir(gi);
                    dir_reg    <= init_dir(gi);
                    ovf_reg    <= 1'b0;
                end else begin
                    ovf_reg <= want_push && full && !pop;
                    if (pop) begin
                        dir_reg    <= mem_reg[rd_ptr_reg[AW-1:0]];
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    end
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                        last_reg   <= dec_dir;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (push) begin
                    mem_reg[wr_ptr_reg[AW-1:0]] <= dec_dir;
                end
            end

            assign dirs[2*gi +: 2] = dir_reg;
            assign overflow[gi]    = ovf_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ps2_dir_queue.sv
// Directed bench for ps2_dir_queue: a two-player instance carries the main
// scenarios, a four-player instance covers the keypad and IJKL keymap rows.
module tb_ps2_dir_queue;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b11;

    logic       clock;
    logic       reset_n;
    logic       ps2_code_new;
    logic [7:0] ps2_code;
    logic       step;

    logic [3:0] dirs2;
    logic       restart2;
    logic [1:0] ovf2;
    logic [7:0] dirs4;
    logic       restart4;
    logic [3:0] ovf4;

    int total = 0;
    int bad   = 0;
    int rst_cnt  = 0;
    int ovf0_cnt = 0;
    int ovf1_cnt = 0;
    int snap;

    ps2_dir_queue #(.NUM_PLAYERS(2), .QUEUE_DEPTH(4)) u_dut2 (
        .clock        (clock),
        .reset_n      (reset_n),
        .ps2_code_new (ps2_code_new),
        .ps2_code     (ps2_code),
        .step         (step),
        .dirs         (dirs2),
        .restart      (restart2),
        .overflow     (ovf2)
    );

    ps2_dir_queue #(.NUM_PLAYERS(4), .QUEUE_DEPTH(4)) u_dut4 (
        .clock        (clock),
        .reset_n      (reset_n),
        .ps2_code_new (ps2_code_new),
        .ps2_code     (ps2_code),
        .step         (step),
        .dirs         (dirs4),
        .restart      (restart4),
        .overflow     (ovf4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse-width counters: every cycle a pulse output is high adds one.
    always @(posedge clock) begin
        #1;
        if (restart2) rst_cnt  = rst_cnt + 1;
        if (ovf2[0])  ovf0_cnt = ovf0_cnt + 1;
        if (ovf2[1])  ovf1_cnt = ovf1_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            $display("check %s: observed=%0d expected=%0d ok", tag, obs, exp);
        end else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        ps2_code     = b;
        ps2_code_new = 1'b1;
        repeat (2) @(negedge clock);
        ps2_code_new = 1'b0;
        repeat (2) @(negedge clock);
        $display("sent byte %02h", b);
    endtask

    task automatic do_step();
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        $display("step: p0=%0d p1=%0d", dirs2[1:0], dirs2[3:2]);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        $display("reset applied");
    endtask

    initial begin
        reset_n      = 1'b0;
        ps2_code_new = 1'b0;
        ps2_code     = 8'h00;
        step         = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset state
        check("rst_p0", dirs2[1:0], RIGHT);
        check("rst_p1", dirs2[3:2], LEFT);
        check("rst_restart", restart2, 1'b0);
        check("rst_overflow", ovf2, 2'b00);
        check("rst_p2_4p", dirs4[5:4], UP);
        check("rst_p3_4p", dirs4[7:6], DOWN);

        // 1: W then step
        send_byte(8'h1D);
        check("t1_no_bypass", dirs2[1:0], RIGHT);
        do_step();
        check("t1_p0_up", dirs2[1:0], UP);
        check("t1_p1_left", dirs2[3:2], LEFT);
        check("t1_restart_none", rst_cnt, 0);

        // 2: extended up arrow, W break ignored
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hF0);
        send_byte(8'h1D);
        do_step();
        check("t2_p1_up", dirs2[3:2], UP);
        check("t2_p0_right", dirs2[1:0], RIGHT);
        check("t2_p2_4p_untouched", dirs4[5:4], UP);
        do_step();
        check("t2_p1_hold", dirs2[3:2], UP);
        check("t2_p0_hold", dirs2[1:0], RIGHT);

        // 3: reversal and repeat filtered
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h23);
        send_byte(8'h1D);
        send_byte(8'h1C);
        check("t3_no_step", dirs2[1:0], RIGHT);
        do_step();
        check("t3_step1_up", dirs2[1:0], UP);
        do_step();
        check("t3_step2_left", dirs2[1:0], LEFT);
        do_step();
        check("t3_step3_hold", dirs2[1:0], LEFT);

        // 4: overflow on fifth legal turn
        do_reset();
        snap = ovf0_cnt;
        send_byte(8'h1D);
        send_byte(8'h1C);
        send_byte(8'h1B);
        send_byte(8'h23);
        check("t4_no_ovf_yet", ovf0_cnt - snap, 0);
        send_byte(8'h1D);
        check("t4_ovf_pulse", ovf0_cnt - snap, 1);
        check("t4_ovf_p1_none", ovf1_cnt, 0);
        do_step();
        check("t4_pop1_up", dirs2[1:0], UP);
        do_step();
        check("t4_pop2_left", dirs2[1:0], LEFT);
        do_step();
        check("t4_pop3_down", dirs2[1:0], DOWN);
        do_step();
        check("t4_pop4_right", dirs2[1:0], RIGHT);
        do_step();
        check("t4_dropped_gone", dirs2[1:0], RIGHT);

        // 5: full queue, step coincides with a new legal code
        do_reset();
        send_byte(8'h1D);
        send_byte(8'h1C);
        send_byte(8'h1B);
        send_byte(8'h23);
        snap = ovf0_cnt;
        @(negedge clock);
        ps2_code     = 8'h1D;
        ps2_code_new = 1'b1;
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        ps2_code_new = 1'b0;
        repeat (2) @(negedge clock);
        $display("sent byte 1d with concurrent step");
        check("t5_no_ovf", ovf0_cnt - snap, 0);
        check("t5_pop1_up", dirs2[1:0], UP);
        do_step();
        check("t5_pop2_left", dirs2[1:0], LEFT);
        do_step();
        check("t5_pop3_down", dirs2[1:0], DOWN);
        do_step();
        check("t5_pop4_right", dirs2[1:0], RIGHT);
        do_step();
        check("t5_pop5_new_up", dirs2[1:0], UP);
        do_step();
        check("t5_empty_hold", dirs2[1:0], UP);

        // 6: space make ignored, space break restarts and flushes
        do_reset();
        send_byte(8'h1D);
        send_byte(8'h1C);
        snap = rst_cnt;
        send_byte(8'h29);
        check("t6_make_no_restart", rst_cnt - snap, 0);
        do_step();
        check("t6_queue_intact", dirs2[1:0], UP);
        send_byte(8'hF0);
        send_byte(8'h29);
        check("t6_restart_pulse", rst_cnt - snap, 1);
        check("t6_p0_restored", dirs2[1:0], RIGHT);
        check("t6_p1_restored", dirs2[3:2], LEFT);
        do_step();
        check("t6_flushed", dirs2[1:0], RIGHT);
        send_byte(8'h1C);
        do_step();
        check("t6_last_reset", dirs2[1:0], RIGHT);

        // 6b: reset after a lone E0 discards the prefix
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h75);
        do_step();
        check("t6b_p1_4p_left", dirs4[3:2], LEFT);
        check("t6b_p2_4p_up", dirs4[5:4], UP);
        check("t6b_p1_2p_left", dirs2[3:2], LEFT);
        send_byte(8'h6B);
        do_step();
        check("t6b_p2_4p_left", dirs4[5:4], LEFT);
        check("t6b_p1_4p_still_left", dirs4[3:2], LEFT);
        send_byte(8'h3B);
        do_step();
        check("t6b_p3_4p_left", dirs4[7:6], LEFT);
        check("t6b_p0_2p_right", dirs2[1:0], RIGHT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_dir_queue.md
Name: ps2_dir_queue

Overview:
- Parametrised keyboard-to-direction front end for up to four players.
- Sits between ps2_keyboard and game_logic.
- Decodes PS/2 set-2 make/break/extended sequences, filters illegal turns, and buffers each player's turns in a per-player FIFO.
- game_logic pops one turn per player per game step, so fast key sequences between ticks are kept rather than overwritten.

Parameters:
NUM_PLAYERS, 2, number of active players, 1..4; keymap rows above NUM_PLAYERS-1 ignored
QUEUE_DEPTH, 4, entries per player FIFO, power of two, 2..16

Ports:
clock  input  1  system clock (CLOCK_50 domain)
reset_n  input  1  synchronous active-low reset
ps2_code_new  input  1  ps2_keyboard strobe, level; new byte on its rising edge
ps2_code  input  8  byte from ps2_keyboard, valid when ps2_code_new rises
step  input  1  one-cycle pulse from game_logic per game tick; pops all queues
dirs  output  2*NUM_PLAYERS  committed dir_t per player, player p in bits [2p+1:2p]
restart  output  1  one-cycle pulse on space release
overflow  output  NUM_PLAYERS  one-cycle pulse per player when a legal turn is dropped on full queue

Behaviour:
- Edge detect:
  - 2-bit history of ps2_code_new; byte event = history 01.
  - Exactly one event per rising edge; a held-high strobe gives no further events.
- Prefix decode:
  - Event E0 sets ext. Event F0 sets brk.
  - Any other byte is consumed with the current ext/brk; both flags clear in the same cycle.
  - Prefixes emit nothing.
- Keymap (make, non-break). Order is up, down, left, right:
  - P0 non-ext 1D,1B,1C,23 (W,S,A,D).
  - P1 ext 75,72,6B,74 (arrows).
  - P2 non-ext 75,72,6B,74 (keypad 8,2,4,6).
  - P3 non-ext 43,42,3B,4B (I,K,J,L).
  - Ext/non-ext must match exactly.
  - Break codes of direction keys are ignored.
  - Unmapped codes are ignored.
- Turn filter:
  - Per player, a last register holds the FIFO tail value, or dirs[p] when the FIFO is empty.
  - A decoded dir equal to last or opposite to last (UP/DOWN, LEFT/RIGHT) is discarded.
  - Otherwise it is pushed, and last is updated if the push succeeds.
- Queue:
  - Push on the decode cycle.
  - If full, no push, last unchanged, overflow[p] pulses for 1 cycle.
  - On step, each non-empty FIFO pops its head into dirs[p] (registered; visible the cycle after step). An empty FIFO keeps dirs[p].
  - step and push in the same cycle: pop first, then push. A push into a full FIFO concurrent with step succeeds.
  - A pushed entry is never bypassed into dirs in the same cycle.
- Restart:
  - Non-ext break of 29 (space) pulses restart for exactly 1 cycle, registered (cycle after the byte event).
  - Same cycle: all FIFOs flushed, dirs reset to initial, last reset, ext/brk cleared.
  - Space make is ignored.
- Reset (reset_n low at clock edge):
  - dirs initial: P0 RIGHT, P1 LEFT, P2 UP, P3 DOWN.
  - FIFOs empty; restart=0; overflow=0; ext=brk=0; edge history=00.
  - Reset mid-sequence (e.g. after E0) discards the pending prefix.
- Latency: byte event -> FIFO entry 1 clock; step -> dirs update 1 clock.
- Width: pointers log2(QUEUE_DEPTH)+1 bits (wrap bit for full/empty); count never exceeds QUEUE_DEPTH.

Test Plan:
1. Reset, NUM_PLAYERS=2: send 1D, then step -> dirs P0=UP one cycle after step, P1=LEFT unchanged; restart=0.
2. Send E0,75 then F0,1D, then two steps -> P1=UP after step 1; P0 stays RIGHT (break ignored); second step no change.
3. P0 at RIGHT, no step: send 1C (LEFT, reversal), 23 (same), 1D, 1C -> queue holds UP,LEFT; steps give UP then LEFT; third step holds LEFT.
4. QUEUE_DEPTH=4, P0 at RIGHT: send UP,LEFT,DOWN,RIGHT,UP with no step -> 5th dropped, overflow[0] 1-cycle pulse; four steps yield UP,LEFT,DOWN,RIGHT.
5. Full P0 queue: step and a new legal code on the same cycle -> no overflow; queue count stays 4; the new entry is popped last.
6. Queue partly full, send 29 (make) -> nothing; then F0,29 -> restart pulses 1 cycle, dirs return to RIGHT/LEFT, next step changes nothing; also assert reset_n low after lone E0, then send 75 -> P2 gets UP, not P1.
